// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Memory-side target for the CPU data-memory load/store port. A request is
// taken on a valid/ready handshake, held for a programmable number of clock
// edges, then committed against a byte-addressable little-endian storage
// array. Completion is signalled with a single-cycle resp_valid strobe.
//
// Parameters:
//   ADDR_WIDTH  byte-address bits backed by storage (2**ADDR_WIDTH bytes)
//   LATENCY     clock edges from acceptance to commit, legal range 1..15
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   req_valid   request present
//   req_ready   responder can accept a request
//   req_write   1 = store, 0 = load
//   req_addr    byte address (64 bits)
//   req_size    transfer size in bytes (1, 2, 4, 8 legal)
//   req_wdata   store data, right-justified, LSB at lowest address
//   resp_valid  one-cycle response strobe
//   resp_rdata  load data, zero-extended, right-justified
//   resp_err    error flag, qualified by resp_valid
//   busy        a request is outstanding
//
// Build option:
//   DATA_MEM_MISALIGN_CHECK_EN  when defined, an access whose address is not
//                               a multiple of its size is reported as an
//                               error (no store, zero read data). Undefined,
//                               misaligned in-range accesses complete
//                               byte-wise.
//
// FSM states:
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | ready for a request; req_ready=1, busy=0
//   S_BUSY | request captured, latency counter running down to 0
//   S_RESP | access committed, resp_valid high for this one cycle

module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [3:0]  req_size,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int MEM_BYTES = 1 << ADDR_WIDTH;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must be in 1..15");
    end
    if (ADDR_WIDTH < 4 || ADDR_WIDTH > 32) begin : g_bad_addr_width
        $error("data_mem_responder: ADDR_WIDTH must be in 4..32");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t      state;
    logic [3:0]  lat_cnt;

    // Captured request; only these copies are used once the request is taken,
    // so the initiator may change its inputs freely while we are busy.
    logic        wr_q;
    logic [63:0] addr_q;
    logic [3:0]  size_q;
    logic [63:0] wdata_q;

    logic [7:0]  mem [MEM_BYTES];

    logic                  size_ok;
    logic                  range_ok;
    logic                  align_ok;
    logic                  acc_err;
    logic [ADDR_WIDTH:0]   end_addr;
    logic [ADDR_WIDTH-1:0] byte_idx [8];
    logic [63:0]           rd_data;
    logic                  commit;
    logic                  mem_we;

    // Commit happens on the edge where the counter has reached zero.
    assign commit = (state == S_BUSY) && (lat_cnt == 4'd0);

    always_comb begin
        size_ok = (size_q == 4'd1) || (size_q == 4'd2) ||
                  (size_q == 4'd4) || (size_q == 4'd8);
    end

    // Last byte touched, computed one bit wider than the array index so that
    // running off the top of storage shows up as a carry instead of wrapping.
    always_comb begin
        end_addr = {1'b0, addr_q[ADDR_WIDTH-1:0]}
                 + (ADDR_WIDTH+1)'(size_q)
                 - (ADDR_WIDTH+1)'(1);
        range_ok = (addr_q[63:ADDR_WIDTH] == '0) && !end_addr[ADDR_WIDTH];
    end

`ifdef DATA_MEM_MISALIGN_CHECK_EN
    // For the legal power-of-two sizes, addr mod size is the low address bits
    // masked by size-1. Illegal sizes are already errors via size_ok.
    always_comb begin
        align_ok = ((addr_q[3:0] & (size_q - 4'd1)) == 4'd0);
    end
`else
    always_comb begin
        align_ok = 1'b1;
    end
`endif

    always_comb begin
        acc_err = !(size_ok && range_ok && align_ok);
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            byte_idx[i] = addr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i);
        end
    end

    // Little-endian gather of the addressed bytes; bytes beyond size stay 0.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < size_q) begin
                rd_data[8*i +: 8] = mem[byte_idx[i]];
            end
        end
    end

    // Reset on the commit edge wins, so a pending store is dropped.
    assign mem_we = commit && wr_q && !acc_err && !reset;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < size_q) begin
                    mem[byte_idx[i]] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            lat_cnt    <= 4'd0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    resp_valid <= 1'b0;
                    if (req_valid) begin
                        wr_q      <= req_write;
                        addr_q    <= req_addr;
                        size_q    <= req_size;
                        wdata_q   <= req_wdata;
                        lat_cnt   <= 4'(LATENCY - 1);
                        state     <= S_BUSY;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (lat_cnt == 4'd0) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= acc_err;
                        // Stores and failed accesses return zero data.
                        resp_rdata <= (acc_err || wr_q) ? 64'd0 : rd_data;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state      <= S_IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    lat_cnt    <= 4'd0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
